// File: rtl/knn_vote_if.sv
// Request/response bundle between the KNN control FSM and the majority-vote block.
// The master side issues start with the neighbour labels; the slave side returns the winning label.
interface knn_vote_if #(
   parameter int NBR_KNN    = 4,
   parameter int LABEL_BITS = 8
);
   localparam int CW = $clog2(NBR_KNN + 1);

   logic                          start;
   logic [NBR_KNN*LABEL_BITS-1:0] nn_labels;
   logic [CW-1:0]                 nbr_valid;
   logic                          busy;
   logic                          done;
   logic [LABEL_BITS-1:0]         label_out;
   logic [CW-1:0]                 votes_out;
   logic                          err;

   modport master (
      output start, nn_labels, nbr_valid,
      input  busy, done, label_out, votes_out, err
   );

   modport slave (
      input  start, nn_labels, nbr_valid,
      output busy, done, label_out, votes_out, err
   );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over the K nearest neighbour labels: histogram build, then a bin scan.
// Optional macro KNN_VOTE_TIE_NEAREST_EN: ties go to the label seen at the nearer neighbour.
module knn_vote #(
   parameter int NBR_KNN    = 4,
   parameter int LABEL_BITS = 8,
   parameter int NBR_LABELS = 4
) (
   input  logic        clk,
   input  logic        rst,
   knn_vote_if.slave   bus
);
   localparam int CW = $clog2(NBR_KNN + 1);
   localparam int IW = (NBR_KNN > 1) ? $clog2(NBR_KNN) : 1;
   localparam int SW = (NBR_LABELS > 1) ? $clog2(NBR_LABELS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_q, state_nx;

   logic [LABEL_BITS-1:0] labels_q [NBR_KNN];
   logic [LABEL_BITS-1:0] labels_in [NBR_KNN];
   logic [CW-1:0]         n_q;
   logic [CW-1:0]         n_in;
   logic [CW-1:0]         j_q;
   logic [SW-1:0]         s_q;
   logic [CW-1:0]         hist_q [NBR_LABELS];
   logic                  err_flag_q;

   logic [SW-1:0]         best_label_q, best_label_nx;
   logic [CW-1:0]         best_cnt_q, best_cnt_nx;

`ifdef KNN_VOTE_TIE_NEAREST_EN
   logic [IW-1:0]         first_idx_q [NBR_LABELS];
   logic [IW-1:0]         best_first_q, best_first_nx;
`endif

   logic [LABEL_BITS-1:0] label_out_q;
   logic [CW-1:0]         votes_out_q;
   logic                  err_out_q;

   logic [LABEL_BITS-1:0] cur_label;
   logic                  cur_valid;
   logic [SW-1:0]         cur_bin;
   logic [CW-1:0]         bin_cnt;
   logic                  take;
   logic                  count_last;
   logic                  scan_last;

   always_comb begin
      for (int i = 0; i < NBR_KNN; i++) begin
         labels_in[i] = bus.nn_labels[i*LABEL_BITS +: LABEL_BITS];
      end
      n_in = (bus.nbr_valid > CW'(NBR_KNN)) ? CW'(NBR_KNN) : bus.nbr_valid;
   end

   always_comb begin
      cur_label  = labels_q[j_q[IW-1:0]];
      cur_valid  = (cur_label < LABEL_BITS'(NBR_LABELS));
      cur_bin    = cur_label[SW-1:0];
      count_last = (j_q == (n_q - CW'(1)));
      scan_last  = (s_q == SW'(NBR_LABELS - 1));
   end

   // Candidate for the running best; empty bins can never beat or tie into the lead.
   always_comb begin
      bin_cnt = hist_q[s_q];
      take    = (bin_cnt > best_cnt_q);
`ifdef KNN_VOTE_TIE_NEAREST_EN
      if ((bin_cnt != '0) && (bin_cnt == best_cnt_q) && (first_idx_q[s_q] < best_first_q)) begin
         take = 1'b1;
      end
      best_first_nx = take ? first_idx_q[s_q] : best_first_q;
`endif
      best_label_nx = take ? s_q     : best_label_q;
      best_cnt_nx   = take ? bin_cnt : best_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_nx = (n_in == '0) ? SCAN : COUNT;
            end
         end
         COUNT: begin
            if (count_last) begin
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if (scan_last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NBR_KNN; i++) begin
            labels_q[i] <= '0;
         end
         for (int l = 0; l < NBR_LABELS; l++) begin
            hist_q[l] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
            first_idx_q[l] <= '0;
`endif
         end
`ifdef KNN_VOTE_TIE_NEAREST_EN
         best_first_q <= '0;
`endif
         n_q          <= '0;
         j_q          <= '0;
         s_q          <= '0;
         err_flag_q   <= 1'b0;
         best_label_q <= '0;
         best_cnt_q   <= '0;
         label_out_q  <= '0;
         votes_out_q  <= '0;
         err_out_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < NBR_KNN; i++) begin
                     labels_q[i] <= labels_in[i];
                  end
                  for (int l = 0; l < NBR_LABELS; l++) begin
                     hist_q[l] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
                     first_idx_q[l] <= '0;
`endif
                  end
`ifdef KNN_VOTE_TIE_NEAREST_EN
                  best_first_q <= '0;
`endif
                  n_q          <= n_in;
                  j_q          <= '0;
                  s_q          <= '0;
                  err_flag_q   <= 1'b0;
                  best_label_q <= '0;
                  best_cnt_q   <= '0;
               end
            end
            COUNT: begin
               if (cur_valid) begin
                  hist_q[cur_bin] <= hist_q[cur_bin] + CW'(1);
`ifdef KNN_VOTE_TIE_NEAREST_EN
                  if (hist_q[cur_bin] == '0) begin
                     first_idx_q[cur_bin] <= j_q[IW-1:0];
                  end
`endif
               end else begin
                  err_flag_q <= 1'b1;
               end
               j_q <= j_q + CW'(1);
            end
            SCAN: begin
               best_label_q <= best_label_nx;
               best_cnt_q   <= best_cnt_nx;
`ifdef KNN_VOTE_TIE_NEAREST_EN
               best_first_q <= best_first_nx;
`endif
               s_q <= s_q + SW'(1);
               // Results land on the same edge that enters DONE so they are valid with the pulse.
               if (scan_last) begin
                  label_out_q <= LABEL_BITS'(best_label_nx);
                  votes_out_q <= best_cnt_nx;
                  err_out_q   <= err_flag_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = (state_q == COUNT) || (state_q == SCAN);
   assign bus.done      = (state_q == DONE);
   assign bus.label_out = label_out_q;
   assign bus.votes_out = votes_out_q;
   assign bus.err       = err_out_q;

endmodule

// File: tb/tb_knn_vote.sv
// Randomized scoreboard bench for knn_vote; the reference vote is computed from label counts.
// Honours KNN_VOTE_TIE_NEAREST_EN the same way as the design build.
module tb_knn_vote;
   localparam int NK = 4;
   localparam int LB = 8;
   localparam int NL = 4;
   localparam int CW = $clog2(NK + 1);

   typedef struct {
      int label;
      int votes;
      int err;
      int done_cycle;
   } exp_t;

   logic clk;
   logic rst;
   int   cycle;
   int   checks;
   int   failures;
   exp_t expq [$];

   knn_vote_if #(.NBR_KNN(NK), .LABEL_BITS(LB)) bus ();

   knn_vote #(.NBR_KNN(NK), .LABEL_BITS(LB), .NBR_LABELS(NL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Reference: count votes per class, take the max; ties by label order or by nearest occurrence.
   function automatic exp_t model(input logic [NK*LB-1:0] packed_labels, input int nv);
      exp_t e;
      int   n;
      int   cnt [NL];
      int   lab [NK];
      int   best;
      n     = (nv > NK) ? NK : nv;
      e.err = 0;
      best  = 0;
      for (int l = 0; l < NL; l++) cnt[l] = 0;
      for (int j = 0; j < NK; j++) lab[j] = int'(packed_labels[j*LB +: LB]);
      for (int j = 0; j < n; j++) begin
         if (lab[j] < NL) cnt[lab[j]]++;
         else e.err = 1;
      end
      for (int l = 0; l < NL; l++) if (cnt[l] > best) best = cnt[l];
      e.votes = best;
      e.label = 0;
      if (best > 0) begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
         for (int j = n - 1; j >= 0; j--) begin
            if (lab[j] < NL && cnt[lab[j]] == best) e.label = lab[j];
         end
`else
         for (int l = NL - 1; l >= 0; l--) begin
            if (cnt[l] == best) e.label = l;
         end
`endif
      end
      e.done_cycle = 0;
      return e;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("done_cycle", cycle, e.done_cycle);
            checkOutput("label_out", bus.label_out, e.label);
            checkOutput("votes_out", bus.votes_out, e.votes);
            checkOutput("err", bus.err, e.err);
            checkOutput("busy_in_done", bus.busy, 0);
         end
      end
   end

   task automatic applyStimulus(input logic [NK*LB-1:0] labels, input int nv, input bit hold);
      exp_t e;
      int   n;
      bit   seen;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.nn_labels = labels;
      bus.nbr_valid = CW'(nv);
      n             = (nv > NK) ? NK : nv;
      e             = model(labels, nv);
      e.done_cycle  = cycle + 1 + n + NL;
      expq.push_back(e);
      @(negedge clk);
      checkOutput("busy_after_start", bus.busy, 1);
      bus.nn_labels = {$urandom, $urandom};
      bus.nbr_valid = CW'($urandom_range(0, 7));
      if (!hold) bus.start = 1'b0;
      seen = 1'b0;
      if (hold) begin
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
         end
         @(negedge clk);
         bus.start = 1'b0;
         @(negedge clk);
         checkOutput("hold_no_restart", bus.busy, 0);
      end else begin
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (expq.size() == 0) seen = 1'b1;
         end
      end
      if (!seen) begin
         checkOutput("done_timeout", 0, 1);
         expq.delete();
      end
   endtask

   initial begin
      logic [NK*LB-1:0] rl;
      checks        = 0;
      failures      = 0;
      cycle         = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.nn_labels = '0;
      bus.nbr_valid = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_label", bus.label_out, 0);
      checkOutput("rst_votes", bus.votes_out, 0);
      checkOutput("rst_err", bus.err, 0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus({8'd3, 8'd1, 8'd2, 8'd2}, 4, 1'b0);
      applyStimulus({8'd3, 8'd1, 8'd1, 8'd3}, 4, 1'b0);
      applyStimulus({8'd9, 8'd0, 8'd7, 8'd7}, 4, 1'b0);
      applyStimulus({8'd1, 8'd2, 8'd3, 8'd0}, 0, 1'b0);
      applyStimulus({8'd0, 8'd0, 8'd2, 8'd2}, 7, 1'b0);
      applyStimulus({8'd3, 8'd3, 8'd1, 8'd2}, 4, 1'b1);

      // Reset in the middle of COUNT: vote is dropped, outputs return to zero.
      applyStimulus({8'd3, 8'd1, 8'd2, 8'd2}, 4, 1'b0);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.nn_labels = {8'd1, 8'd1, 8'd1, 8'd1};
      bus.nbr_valid = CW'(4);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_done", bus.done, 0);
      checkOutput("midrst_label", bus.label_out, 0);
      checkOutput("midrst_votes", bus.votes_out, 0);
      checkOutput("midrst_err", bus.err, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      applyStimulus({8'd3, 8'd1, 8'd2, 8'd2}, 4, 1'b0);

      for (int t = 0; t < 40; t++) begin
         for (int j = 0; j < NK; j++) begin
            rl[j*LB +: LB] = ($urandom_range(0, 9) == 0) ? LB'($urandom) : LB'($urandom_range(0, NL));
         end
         applyStimulus(rl, int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      end

      repeat (5) @(negedge clk);
      checkOutput("queue_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
